// File: rtl/shift_controller_if.sv
// Request/result bundle for shift_controller: the master issues shift requests, the slave
// returns the registered result with a one-cycle ready pulse.
interface shift_controller_if;
  logic        ctrl_start;
  logic [1:0]  ctrl_op;
  logic [4:0]  ctrl_shamt;
  logic [31:0] data_operand;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  modport master (
    output ctrl_start,
    output ctrl_op,
    output ctrl_shamt,
    output data_operand,
    input  data_result,
    input  data_resultRDY,
    input  data_exception,
    input  busy
  );

  modport slave (
    input  ctrl_start,
    input  ctrl_op,
    input  ctrl_shamt,
    input  data_operand,
    output data_result,
    output data_resultRDY,
    output data_exception,
    output busy
  );
endinterface

// File: rtl/shift_controller.sv
// Multi-cycle barrel shifter: one power-of-two stage per SHIFT cycle, k = 4 down to 0.
// Define SHIFT_EARLY_EXIT_EN to finish as soon as no lower shamt bits remain set.
module shift_controller (
  input logic               clock,
  input logic               reset,
  shift_controller_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSra = 2'b01;
  localparam logic [1:0] OpRsv = 2'b11;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] result_q, result_d;
  logic        rdy_q, rdy_d;
  logic        exc_q, exc_d;

  logic [31:0] amt;
  logic [31:0] shifted;
  logic [31:0] stage_val;
  logic [4:0]  low_mask;
  logic        last_stage;

  // Datapath for the stage selected by k_q.
  always_comb begin
    amt      = 32'd1 << k_q;
    low_mask = (5'd1 << k_q) - 5'd1;
    case (op_q)
      OpSll:   shifted = acc_q << amt;
      OpSra:   shifted = $unsigned($signed(acc_q) >>> amt);
      default: shifted = acc_q >> amt;
    endcase
    stage_val = shamt_q[k_q] ? shifted : acc_q;
`ifdef SHIFT_EARLY_EXIT_EN
    last_stage = ((shamt_q & low_mask) == 5'd0);
`else
    last_stage = (k_q == 3'd0) || (low_mask == 5'h1f);
`endif
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    exc_d    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.ctrl_start) begin
          acc_d   = bus.data_operand;
          op_d    = bus.ctrl_op;
          shamt_d = bus.ctrl_shamt;
          k_d     = 3'd4;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (op_q == OpRsv) begin
          result_d = acc_q;
          rdy_d    = 1'b1;
          exc_d    = 1'b1;
          k_d      = 3'd4;
          state_d  = StDone;
        end else begin
          acc_d = stage_val;
          k_d   = k_q - 3'd1;
          if (last_stage) begin
            result_d = stage_val;
            rdy_d    = 1'b1;
            k_d      = 3'd4;
            state_d  = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= 3'd4;
      acc_q    <= 32'd0;
      op_q     <= 2'b00;
      shamt_q  <= 5'd0;
      result_q <= 32'd0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_exception = exc_q;
  assign bus.busy           = (state_q == StShift);

endmodule

// File: doc/shift_controller.md
SHIFT_CONTROLLER -- requirements
Module: shift_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with clock and reset listed first.
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
REQ-002 ctrl_start  input  1: request pulse, sampled only in IDLE or DONE.
REQ-003 ctrl_op  input  2: operation select.
- 00 = SLL (logical left)
- 01 = SRA (arithmetic right)
- 10 = SRL (logical right)
- 11 = reserved
REQ-004 ctrl_shamt  input  5: shift amount, 0-31.
REQ-005 data_operand  input  32: value to shift.
REQ-006 data_result  output  32: shifted value; holds until the next accepted request.
REQ-007 data_resultRDY  output  1: one-cycle pulse, result valid.
REQ-008 data_exception  output  1: valid with data_resultRDY; set for a reserved op.
REQ-009 busy  output  1: high in SHIFT state.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-011 Accepting a request: ctrl_start=1 in IDLE or DONE at edge E0 SHALL do the following.
- latch ctrl_op, ctrl_shamt and data_operand into an internal accumulator
- set stage index k=4
- go to SHIFT
REQ-012 Each SHIFT cycle processes one stage k, from 4 down to 0.
- if shamt[k]=1, the accumulator is shifted by 2^k positions in the latched direction
- otherwise it is unchanged
- k decrements after each stage
REQ-013 Fill bits SHALL be zeros for SLL and SRL, and copies of accumulator bit 31 for SRA.
REQ-014 After stage 0 is applied (edge E5), the block SHALL go to DONE, load data_result from the accumulator and register data_resultRDY=1.
- data_resultRDY is high exactly in the cycle after E5.
REQ-015 DONE SHALL last one cycle, then return to IDLE unless a new request is accepted at that edge (back-to-back, no bubble).
REQ-016 ctrl_start while busy=1 SHALL be ignored; there is no queueing.
REQ-017 Reserved op (ctrl_op=11) SHALL do the following.
- go to DONE at E1
- data_result = latched operand unmodified
- data_exception = 1 together with data_resultRDY
REQ-018 data_exception SHALL be 0 at all times except in a reserved-op DONE cycle.
REQ-019 Inputs changing after E0 SHALL NOT affect the operation in progress.
REQ-020 shamt=0 SHALL return the operand unchanged with full (configuration-dependent) latency.

Reset
REQ-021 While reset=1 at a rising edge, the block SHALL clear state and outputs.
- state = IDLE, k = 4, accumulator = 0
- data_result = 0, data_resultRDY = 0, data_exception = 0, busy = 0
REQ-022 Reset SHALL take priority over ctrl_start.
REQ-023 Reset asserted mid-operation SHALL abort the operation; no data_resultRDY is produced for it.

Configuration
REQ-024 Macro SHIFT_EARLY_EXIT_EN SHALL control early completion.
- Defined: after applying stage k, if the latched shamt[k-1:0]==0 (always true at k=0), go to DONE immediately.
  - shamt=0 → DONE at E1
  - shamt=16 → DONE at E1
  - shamt=1 → DONE at E5
- Undefined: all five stages are always executed and data_resultRDY comes 5 edges after E0.
- Either way, data_result SHALL be identical.

Verification
REQ-025 Directed scenarios the bench must cover:
- SLL: operand 0x0000_000F, shamt 4, op 00 → data_result 0x0000_00F0, data_resultRDY one cycle after E5 (no macro), exception 0.
- SRA: operand 0x8000_0000, shamt 31, op 01 → 0xFFFF_FFFF; SRL with the same operand, op 10 → 0x0000_0001.
- Reserved op: op 11, operand 0x1234_5678 → data_result 0x1234_5678, data_exception=1, data_resultRDY in the cycle after E1.
- Back-to-back: ctrl_start held high continuously → second request accepted in the DONE cycle, busy high again next cycle. A third ctrl_start pulsed while busy is ignored.
- Reset mid-operation: reset at E3 → all outputs 0, no data_resultRDY pulse. A new request afterwards completes correctly.
- With SHIFT_EARLY_EXIT_EN: shamt 0 and shamt 16 each give data_resultRDY the cycle after E1, with results operand and operand<<16.
